// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the sequencer and its driver.
// Master drives control and flags; slave returns PC and stack status.
interface pc_sequencer_if #(
    parameter int ADDR_W = 8
);
    logic              stall;
    logic [2:0]        PC_control;
    logic [3:0]        jump_condition;
    logic [ADDR_W-1:0] jump_address;
    logic              Z_out;
    logic              N_out;
    logic [ADDR_W-1:0] IRAM_address;
    logic              branch_taken;
    logic              stack_full;
    logic              stack_empty;
    logic              stack_err;

    modport master (
        output stall, PC_control, jump_condition, jump_address, Z_out, N_out,
        input  IRAM_address, branch_taken, stack_full, stack_empty, stack_err
    );

    modport slave (
        input  stall, PC_control, jump_condition, jump_address, Z_out, N_out,
        output IRAM_address, branch_taken, stack_full, stack_empty, stack_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// Program counter sequencer: hold/increment/conditional jump, plus
// call/return on a small return stack when PC_SEQ_STACK_EN is defined.
module pc_sequencer #(
    parameter int          ADDR_W       = 8,
    parameter int          STACK_DEPTH  = 4,
    parameter int unsigned RESET_VECTOR = 0
) (
    input  logic           i_clock,
    input  logic           i_reset,
    pc_sequencer_if.slave  bus
);
    logic [ADDR_W-1:0] r_pc;
    logic              r_taken;
    logic [ADDR_W-1:0] w_pc_inc;
    logic [ADDR_W-1:0] w_pc_nxt;
    logic              w_br;
    logic              w_cond;
    logic              w_op_inc;
    logic              w_op_jmp;

    assign w_pc_inc = r_pc + ADDR_W'(1);
    assign w_op_inc = (bus.PC_control == 3'b001);
    assign w_op_jmp = (bus.PC_control == 3'b010);

    always_comb begin
        w_cond = 1'b0;
        case (bus.jump_condition)
            4'b0000: w_cond = 1'b1;
            4'b0001: w_cond = !bus.Z_out;
            4'b0010: w_cond = bus.Z_out;
            4'b0011: w_cond = bus.N_out;
            4'b0100: w_cond = !bus.N_out;
            default: w_cond = 1'b0;
        endcase
    end

`ifdef PC_SEQ_STACK_EN
    localparam int SP_W = $clog2(STACK_DEPTH + 1);

    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];
    logic [SP_W-1:0]   r_sp;
    logic              r_err;
    logic [ADDR_W-1:0] w_top;
    logic              w_full;
    logic              w_empty;
    logic              w_op_call;
    logic              w_op_ret;
    logic              w_push;
    logic              w_pop;
    logic              w_err_set;

    assign w_full    = (r_sp == SP_W'(STACK_DEPTH));
    assign w_empty   = (r_sp == '0);
    assign w_op_call = (bus.PC_control == 3'b011);
    assign w_op_ret  = (bus.PC_control == 3'b100);

    // Top-of-stack lives at entry sp-1
    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_sp == SP_W'(i + 1)) w_top = r_stack[i];
        end
    end

    always_comb begin
        w_pc_nxt  = r_pc;
        w_br      = 1'b0;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
        unique case (1'b1)
            w_op_inc: w_pc_nxt = w_pc_inc;
            w_op_jmp: begin
                if (w_cond) begin
                    w_pc_nxt = bus.jump_address;
                    w_br     = 1'b1;
                end
            end
            w_op_call: begin
                if (w_cond && !w_full) begin
                    w_pc_nxt = bus.jump_address;
                    w_br     = 1'b1;
                    w_push   = 1'b1;
                end else begin
                    w_pc_nxt  = w_pc_inc;
                    w_err_set = w_cond;
                end
            end
            w_op_ret: begin
                if (!w_empty) begin
                    w_pc_nxt = w_top;
                    w_br     = 1'b1;
                    w_pop    = 1'b1;
                end else begin
                    w_pc_nxt  = w_pc_inc;
                    w_err_set = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_sp  <= '0;
            r_err <= 1'b0;
        end else if (!bus.stall) begin
            r_err <= r_err | w_err_set;
            if (w_push)     r_sp <= r_sp + SP_W'(1);
            else if (w_pop) r_sp <= r_sp - SP_W'(1);
        end
    end

    // Entries need no reset: nothing reads above the pointer
    always_ff @(posedge i_clock) begin
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (!i_reset && !bus.stall && w_push && r_sp == SP_W'(i))
                r_stack[i] <= w_pc_inc;
        end
    end

    assign bus.stack_full  = w_full;
    assign bus.stack_empty = w_empty;
    assign bus.stack_err   = r_err;
`else
    always_comb begin
        w_pc_nxt = r_pc;
        w_br     = 1'b0;
        unique case (1'b1)
            w_op_inc: w_pc_nxt = w_pc_inc;
            w_op_jmp: begin
                if (w_cond) begin
                    w_pc_nxt = bus.jump_address;
                    w_br     = 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.stack_full  = 1'b0;
    assign bus.stack_empty = 1'b1;
    assign bus.stack_err   = 1'b0;
`endif

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pc    <= ADDR_W'(RESET_VECTOR);
            r_taken <= 1'b0;
        end else if (bus.stall) begin
            r_taken <= 1'b0;
        end else begin
            r_pc    <= w_pc_nxt;
            r_taken <= w_br;
        end
    end

    assign bus.IRAM_address = r_pc;
    assign bus.branch_taken = r_taken;
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 8, program-counter and IRAM address width (4..16).
REQ-002 The block SHALL have parameter STACK_DEPTH, default 4, return-stack entries (1..16).
REQ-003 The block SHALL have parameter RESET_VECTOR, default 0, PC value loaded on reset.
REQ-004 The block SHALL have port clock, input, 1 bit, single clock; all state updates on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit, synchronous, active-high.
REQ-006 The block SHALL have port stall, input, 1 bit, freezes all state when high.
REQ-007 The block SHALL have port PC_control, input, 3 bits, selecting the operation: 000 hold, 001 increment, 010 jump, 011 call, 100 return, others hold.
REQ-008 The block SHALL have port jump_condition, input, 4 bits, condition code for jump and call.
REQ-009 The block SHALL have port jump_address, input, ADDR_W bits, target for jump and call.
REQ-010 The block SHALL have port Z_out, input, 1 bit, ALU zero flag.
REQ-011 The block SHALL have port N_out, input, 1 bit, ALU negative flag.
REQ-012 The block SHALL have port IRAM_address, output, ADDR_W bits, current PC register value.
REQ-013 The block SHALL have port branch_taken, output, 1 bit, registered; high for the cycle after a taken jump, call or return.
REQ-014 The block SHALL have ports stack_full and stack_empty, outputs, 1 bit each, combinational from the stack pointer.
REQ-015 The block SHALL have port stack_err, output, 1 bit, sticky overflow/underflow flag.

Function
REQ-016 Conditions SHALL be evaluated as follows: 0000 always; 0001 Z_out==0; 0010 Z_out==1; 0011 N_out==1; 0100 N_out==0; any other code is never taken.
REQ-017 Flags SHALL be sampled in the same cycle as PC_control; PC and stack update on that rising edge, giving one-cycle latency.
REQ-018 Hold SHALL leave PC unchanged.
REQ-019 Increment SHALL set PC to PC+1 modulo 2^ADDR_W, so all-ones wraps to 0.
REQ-020 Jump SHALL load jump_address when the condition is taken and leave PC unchanged when it is not (legacy semantics).
REQ-021 Call, when taken and the stack is not full, SHALL push PC+1 (wrapped), load jump_address, and increment the stack pointer.
REQ-022 Call, when not taken, SHALL set PC to PC+1 with the stack untouched.
REQ-023 Call, when taken with the stack full, SHALL not push, SHALL set PC to PC+1, and SHALL set stack_err.
REQ-024 Return with a non-empty stack SHALL pop the top entry into PC and decrement the stack pointer; the condition is ignored.
REQ-025 Return with an empty stack SHALL set PC to PC+1 and SHALL set stack_err.
REQ-026 stall=1 SHALL hold PC, stack, and stack_err, and SHALL drive branch_taken low next cycle, regardless of PC_control.
REQ-027 Priority SHALL be reset > stall > PC_control.
REQ-028 stack_full SHALL equal (pointer==STACK_DEPTH) and stack_empty SHALL equal (pointer==0).
REQ-029 Stack pointer width SHALL be clog2(STACK_DEPTH+1).
REQ-030 Once set, stack_err SHALL be cleared only by reset.

Reset
REQ-031 On a clock edge with reset=1, the block SHALL set PC=RESET_VECTOR, pointer=0, stack_err=0, branch_taken=0, overriding stall and any in-progress call/return.
REQ-032 Stack entry contents SHALL not require reset; they are unreadable until pushed.
REQ-033 After reset the block SHALL present IRAM_address=RESET_VECTOR, stack_empty=1, and stack_full=0.

Configuration
REQ-034 The feature SHALL be controlled by macro PC_SEQ_STACK_EN.
REQ-035 With PC_SEQ_STACK_EN defined, the block SHALL implement call/return and the stack as specified above.
REQ-036 Without PC_SEQ_STACK_EN, no stack storage SHALL exist; call and return SHALL behave as hold; stack_full=0, stack_empty=1, and stack_err=0 constantly; all other behaviour SHALL be identical.

Verification
REQ-037 The bench SHALL cover: reset, then 5 cycles of PC_control=001 -> IRAM_address 0,1,2,3,4,5; with ADDR_W=8 from PC=0xFF, increment -> 0x00.
REQ-038 The bench SHALL cover: PC=0x10, jump cond 0001, Z_out=1 -> PC stays 0x10, branch_taken=0; repeat with Z_out=0 -> PC=jump_address 0x40, branch_taken=1 next cycle.
REQ-039 The bench SHALL cover: PC=0x20, call 0x80 cond 0000, then return -> PC 0x80, then 0x21; stack_empty 1->0->1.
REQ-040 The bench SHALL cover: STACK_DEPTH=4, five taken calls -> fifth gives PC=caller+1, stack_full=1, stack_err=1; return on empty stack -> PC+1, stack_err stays 1.
REQ-041 The bench SHALL cover: stall=1 with PC_control=011 -> PC, pointer, and flags unchanged; reset=1 together with stall=1 -> PC=RESET_VECTOR, pointer=0, stack_err=0.
REQ-042 The bench SHALL cover: build without PC_SEQ_STACK_EN, call 0x80 at PC=0x20 -> PC stays 0x20, stack_empty=1, stack_err=0.
